ttl_and_bank_filtered: RTL and testbench

Parametrised bank of AND gates in the style of the 7421 dual 4-input AND, generalised in channel count and inputs per gate. Each channel adds a per-input mask, a registered input sample and a digital stability filter. An output changes only after its AND result has been stable for FILTER clocks. Used where TTL-model gate outputs feed sequential logic and must be glitch-free and synchronous.

---
 rtl/ttl_and_bank_filtered.sv | 117 +++++++++++
 tb/tb_ttl_and_bank_filtered.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ttl_and_bank_filtered.sv
// ---------------------------------------------------------------------------
// ttl_and_bank_filtered
//
// Bank of CHANNELS independent AND gates, each with INPUTS inputs, modelled
// on the 7421 dual 4-input AND. Every channel has a per-input mask, a
// registered sample of the raw AND result and a stability filter. Y follows
// a new result only after that result has persisted for FILTER clocks, so
// the outputs are glitch-free and synchronous to CLK.
//
// Optional build macro: TTL_AND_BANK_NAND_EN
//   Defined     -> NAND bank (7420 style). Filtering still runs on the AND
//                  result; Y is the inverse of the filtered state, so Y
//                  resets to all ones. CHG and BUSY are unaffected.
//   Not defined -> plain AND outputs, Y resets to all zeros.
//
// Parameters:
//   CHANNELS  number of gates (>=1)
//   INPUTS    inputs per gate (>=2)
//   FILTER    clocks a new result must persist before Y follows (>=1)
//
// Ports:
//   CLK   in   1                  rising-edge clock
//   RST   in   1                  asynchronous active-high reset
//   EN    in   1                  clock enable, low freezes all state
//   IN    in   CHANNELS*INPUTS    gate inputs, channel c at [c*INPUTS +: INPUTS]
//   MASK  in   CHANNELS*INPUTS    1 = input used, 0 = input treated as 1
//   Y     out  CHANNELS           filtered, registered outputs
//   CHG   out  CHANNELS           one-cycle strobe on the edge Y[c] changes
//   BUSY  out  1                  any channel has an unconfirmed change
// ---------------------------------------------------------------------------
module ttl_and_bank_filtered #(
    parameter int CHANNELS = 2,
    parameter int INPUTS   = 4,
    parameter int FILTER   = 3
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         EN,
    input  logic [CHANNELS*INPUTS-1:0]   IN,
    input  logic [CHANNELS*INPUTS-1:0]   MASK,
    output logic [CHANNELS-1:0]          Y,
    output logic [CHANNELS-1:0]          CHG,
    output logic                         BUSY
);

    // Counter only needs to reach FILTER-1; keep at least one bit.
    localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] samp_q;
    logic [CHANNELS-1:0] state_q;   // filtered AND result, before polarity
    logic [CHANNELS-1:0] chg_q;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [INPUTS-1:0] in_c;
            logic [INPUTS-1:0] mask_c;
            logic [CW-1:0]     cnt_q;
            logic [CW-1:0]     cnt_d;
            logic              samp_d;
            logic              state_d;
            logic              chg_d;

            assign in_c   = IN[gi*INPUTS +: INPUTS];
            assign mask_c = MASK[gi*INPUTS +: INPUTS];

            // Masked-off pins read as 1, so an all-zero mask yields RAW = 1.
            assign raw[gi] = &(in_c | ~mask_c);

            always_comb begin
                samp_d  = samp_q[gi];
                cnt_d   = cnt_q;
                state_d = state_q[gi];
                chg_d   = 1'b0;     // strobe is never held, including EN=0
                if (EN) begin
                    samp_d = raw[gi];
                    if (samp_q[gi] == state_q[gi]) begin
                        // Result agrees with output: discard any partial count.
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = samp_q[gi];
                        cnt_d   = '0;
                        chg_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    samp_q[gi]  <= 1'b0;
                    cnt_q       <= '0;
                    state_q[gi] <= 1'b0;
                    chg_q[gi]   <= 1'b0;
                end else begin
                    samp_q[gi]  <= samp_d;
                    cnt_q       <= cnt_d;
                    state_q[gi] <= state_d;
                    chg_q[gi]   <= chg_d;
                end
            end
        end
    endgenerate

`ifdef TTL_AND_BANK_NAND_EN
    assign Y = ~state_q;
`else
    assign Y = state_q;
`endif

    assign CHG  = chg_q;
    assign BUSY = |(samp_q ^ state_q);

endmodule

// File: tb/tb_ttl_and_bank_filtered.sv
// ---------------------------------------------------------------------------
// tb_ttl_and_bank_filtered
//
// Directed testbench for ttl_and_bank_filtered at default parameters
// (CHANNELS=2, INPUTS=4, FILTER=3). Expected values are hand-derived from
// the filter latency: a result first sampled at edge 0 reaches Y at edge 3.
// Y expectations are given in AND polarity and inverted when the NAND build
// macro is defined.
// ---------------------------------------------------------------------------
module tb_ttl_and_bank_filtered;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic [7:0] IN;
    logic [7:0] MASK;
    logic [1:0] Y;
    logic [1:0] CHG;
    logic       BUSY;

    int n_checks;
    int n_errors;

`ifdef TTL_AND_BANK_NAND_EN
    localparam logic [1:0] YINV = 2'b11;
`else
    localparam logic [1:0] YINV = 2'b00;
`endif

    ttl_and_bank_filtered #(
        .CHANNELS (2),
        .INPUTS   (4),
        .FILTER   (3)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .IN   (IN),
        .MASK (MASK),
        .Y    (Y),
        .CHG  (CHG),
        .BUSY (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Output checks: Y given in AND polarity.
    task automatic expect_out(input string tag, input logic [1:0] y_and,
                              input logic [1:0] chg, input logic busy);
        check({tag, ".Y"},    {30'd0, Y},    {30'd0, y_and ^ YINV});
        check({tag, ".CHG"},  {30'd0, CHG},  {30'd0, chg});
        check({tag, ".BUSY"}, {31'd0, BUSY}, {31'd0, busy});
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must
    // reflect reset before the next edge.
    task automatic pulse_reset(input string tag);
        #2 RST = 1'b1;
        #1 expect_out(tag, 2'b00, 2'b00, 1'b0);
        #1 RST = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST  = 1'b1;
        EN   = 1'b1;
        IN   = 8'h00;
        MASK = 8'hFF;
        #2 expect_out("reset_init", 2'b00, 2'b00, 1'b0);
        step();
        #1 RST = 1'b0;
        step();
        expect_out("idle", 2'b00, 2'b00, 1'b0);

        // Rising output on ch0.
        IN = 8'h0F;
        step(); expect_out("rise.e0", 2'b00, 2'b00, 1'b1);
        step(); expect_out("rise.e1", 2'b00, 2'b00, 1'b1);
        step(); expect_out("rise.e2", 2'b00, 2'b00, 1'b1);
        step(); expect_out("rise.e3", 2'b01, 2'b01, 1'b0);
        step(); expect_out("rise.e4", 2'b01, 2'b00, 1'b0);

        // Async reset with Y high.
        pulse_reset("reset_async");
        IN = 8'h00;

        // Glitch rejection: 1111 for two edges then 0111.
        step();
        IN = 8'h0F;
        step(); expect_out("glitch.e0", 2'b00, 2'b00, 1'b1);
        step(); expect_out("glitch.e1", 2'b00, 2'b00, 1'b1);
        IN = 8'h07;
        step(); expect_out("glitch.e2", 2'b00, 2'b00, 1'b0);
        step(); expect_out("glitch.e3", 2'b00, 2'b00, 1'b0);
        step(); expect_out("glitch.e4", 2'b00, 2'b00, 1'b0);

        // Masking on ch1.
        pulse_reset("reset_mask");
        IN   = 8'h30;
        MASK = 8'h3F;
        step(); expect_out("mask.e0", 2'b00, 2'b00, 1'b1);
        step();
        step(); expect_out("mask.e2", 2'b00, 2'b00, 1'b1);
        step(); expect_out("mask.e3", 2'b10, 2'b10, 1'b0);
        MASK = 8'h0F;
        IN   = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step(); expect_out("mask.empty", 2'b10, 2'b00, 1'b0);
        end

        // Enable freeze mid-count.
        pulse_reset("reset_en");
        MASK = 8'hFF;
        IN   = 8'h0F;
        step();
        step(); expect_out("en.e1", 2'b00, 2'b00, 1'b1);
        EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); expect_out("en.frozen", 2'b00, 2'b00, 1'b1);
        end
        EN = 1'b1;
        step(); expect_out("en.re1", 2'b00, 2'b00, 1'b1);
        step(); expect_out("en.re2", 2'b01, 2'b01, 1'b0);

        // Reset mid-count, then full latency again.
        pulse_reset("reset_pre");
        IN = 8'h0F;
        step();
        step(); expect_out("midrst.cnt1", 2'b00, 2'b00, 1'b1);
        pulse_reset("midrst.pulse");
        step(); expect_out("midrst.e0", 2'b00, 2'b00, 1'b1);
        step();
        step(); expect_out("midrst.e2", 2'b00, 2'b00, 1'b1);
        step(); expect_out("midrst.e3", 2'b01, 2'b01, 1'b0);

        // Both channels change together; then ch0 falls.
        IN = 8'hFF;
        step(); expect_out("both.e0", 2'b01, 2'b00, 1'b1);
        step();
        step();
        step(); expect_out("both.e3", 2'b11, 2'b10, 1'b0);
        IN = 8'hF0;
        step(); expect_out("fall.e0", 2'b11, 2'b00, 1'b1);
        step();
        step();
        step(); expect_out("fall.e3", 2'b10, 2'b01, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
